arb_mux: RTL and testbench

Arbitrated channel multiplexer that sits directly downstream of the round-robin arbiter. It presents per-channel requests to the arbiter and consumes the arbiter's one-hot grant. It steers the granted channel's beat into a 2-entry output buffer and holds the selection for the full duration of a multi-beat packet. Output is a single valid/ready stream tagged with the source channel index.

---
 rtl/arb_mux_pkg.sv | 19 +
 rtl/arb_mux_if.sv | 31 +++
 rtl/arb_mux_skid.sv | 49 ++++
 rtl/arb_mux.sv | 116 +++++++++++
 tb/tb_arb_mux.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arbitrated channel multiplexer.
package arb_pkg;

    // Selection FSM: IDLE arbitrates every beat, LOCK holds one owner until end-of-packet.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // Index of the lowest set bit of a (nominally one-hot) vector of up to 32 lanes.
    // Callers zero-extend their vector and truncate the result to their index width.
    function automatic logic [4:0] oh2idx(input logic [31:0] oh);
        oh2idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (oh[i]) oh2idx = 5'(i);
        end
    endfunction

endpackage

// File: rtl/arb_mux_if.sv
// Handshake bundle for arb_mux: per-channel inputs, arbiter req/gnt and the output stream.
interface arb_mux_if #(
    parameter int WIDTH = 4,
    parameter int DW    = 32
) ();
    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0]    in_vld;
    logic [WIDTH*DW-1:0] in_data;
    logic [WIDTH-1:0]    in_last;
    logic [WIDTH-1:0]    in_rdy;
    logic [WIDTH-1:0]    arb_req;
    logic [WIDTH-1:0]    arb_gnt;
    logic                out_vld;
    logic [DW-1:0]       out_data;
    logic                out_last;
    logic [SW-1:0]       out_src;
    logic                out_rdy;

    // Mux side
    modport slave (
        input  in_vld, in_data, in_last, arb_gnt, out_rdy,
        output in_rdy, arb_req, out_vld, out_data, out_last, out_src
    );

    // Channel sources, arbiter and downstream sink side
    modport master (
        output in_vld, in_data, in_last, arb_gnt, out_rdy,
        input  in_rdy, arb_req, out_vld, out_data, out_last, out_src
    );
endinterface

// File: rtl/arb_mux_skid.sv
// Two-entry FIFO between the channel select and the output stream.
// Space is derived from the registered count only, so downstream ready
// never reaches the input side combinationally.
module arb_mux_skid #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [PW-1:0] push_data,
    input  logic          rdy,
    output logic          space,
    output logic          vld,
    output logic [PW-1:0] head
);
    logic [PW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          pop;

    assign space = (count < 2'd2);
    assign vld   = (count != 2'd0);
    assign pop   = vld & rdy;
    // Head is forced to zero when empty so the output fields read zero after reset.
    assign head  = vld ? mem[rd_ptr] : '0;

    // Pointer and occupancy tracking; push+pop together leaves count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/arb_mux.sv
// Arbitrated channel multiplexer downstream of a round-robin arbiter.
// Presents requests to the arbiter, takes its one-hot grant in the same cycle,
// and pushes the granted beat tagged with its channel index into a 2-entry buffer.
// Build option ARB_MUX_LOCK_EN: when defined, a multi-beat packet holds the
// selection until its last beat; otherwise every beat is arbitrated on its own.
module arb_mux
    import arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DW    = 32
) (
    input logic      clk,
    input logic      rst,
    arb_mux_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int PW = DW + 1 + SW;

    logic             space;
    logic             out_vld_w;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] req;
    logic [WIDTH-1:0] rdy;
    logic [SW-1:0]    sel;
    logic [DW-1:0]    pdata;
    logic             plast;
    logic             push;
    logic [PW-1:0]    head;
`ifdef ARB_MUX_LOCK_EN
    arb_state_e    state_q, state_d;
    logic [SW-1:0] owner_q, owner_d;
`endif

    // Arbiter request: only when a beat could actually be taken, so the arbiter
    // never rotates priority without a transfer. Kept apart from the grant path.
    always_comb begin
        req = bus.in_vld & {WIDTH{space}};
`ifdef ARB_MUX_LOCK_EN
        if (state_q == ARB_LOCK) req = '0;
`endif
        if (rst) req = '0;
    end

    // Accept: lowest valid granted channel in IDLE, or the locked owner in LOCK
    always_comb begin
        cand = bus.arb_gnt & bus.in_vld & {WIDTH{space}};
        rdy  = cand & (~cand + WIDTH'(1));
`ifdef ARB_MUX_LOCK_EN
        if (state_q == ARB_LOCK) begin
            rdy          = '0;
            rdy[owner_q] = bus.in_vld[owner_q] & space;
        end
`endif
        if (rst) rdy = '0;
    end

    assign bus.arb_req = req;
    assign bus.in_rdy  = rdy;
    assign push        = |rdy;
    assign sel         = SW'(oh2idx(32'(rdy)));

    // Steer the accepted channel's payload and end-of-packet flag
    always_comb begin
        pdata = '0;
        plast = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (rdy[i]) begin
                pdata = bus.in_data[i*DW +: DW];
                plast = bus.in_last[i];
            end
        end
    end

`ifdef ARB_MUX_LOCK_EN
    // Lock state and packet owner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Lock on a non-final beat taken in IDLE, release on the owner's final beat
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (push) begin
            case (state_q)
                ARB_IDLE: if (!plast) begin
                    state_d = ARB_LOCK;
                    owner_d = sel;
                end
                ARB_LOCK: if (plast) state_d = ARB_IDLE;
                default:  state_d = ARB_IDLE;
            endcase
        end
    end
`endif

    arb_mux_skid #(.PW(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({pdata, plast, sel}),
        .rdy       (bus.out_rdy),
        .space     (space),
        .vld       (out_vld_w),
        .head      (head)
    );

    assign bus.out_vld = out_vld_w;
    assign {bus.out_data, bus.out_last, bus.out_src} = head;
endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: models the upstream round-robin arbiter and per-channel
// packet sources, and checks the output stream against an expected-beat queue.
module tb_arb_mux;
    localparam int WIDTH = 4;
    localparam int DW    = 32;

    typedef struct packed {
        logic [1:0]  src;
        logic        last;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] gnt;
        logic [3:0] rdy;
        logic [3:0] req;
        logic [1:0] src;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    arb_mux_if #(.WIDTH(WIDTH), .DW(DW)) bus ();
    arb_mux #(.WIDTH(WIDTH), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [32:0] srcq [WIDTH][$];
    beat_t       sb [$];
    logic [3:0]  acc;
    logic        direct   = 1'b0;
    logic        force_en = 1'b0;
    logic [3:0]  force_gnt = '0;
    logic [1:0]  ptr;
    logic [1:0]  rr_c;
    vec_t        vt [9];
    int          cyc;

    function automatic logic [1:0] lowidx(input logic [3:0] v);
        lowidx = '0;
        for (int k = 3; k >= 0; k--) if (v[k]) lowidx = 2'(k);
    endfunction

    // Round-robin arbiter model: first requester at or after ptr, same cycle
    always_comb begin
        bus.arb_gnt = '0;
        rr_c = '0;
        if (force_en) bus.arb_gnt = force_gnt;
        else begin
            for (int k = 3; k >= 0; k--) begin
                rr_c = ptr + 2'(k);
                if (bus.arb_req[rr_c]) bus.arb_gnt = 4'b0001 << rr_c;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) ptr <= '0;
        else if (!force_en && (bus.arb_gnt & bus.in_rdy) != '0) ptr <= lowidx(bus.arb_gnt) + 2'd1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dv(input int ch, input int n);
        return 32'hA000_0000 + 32'(ch * 256 + n);
    endfunction

    task automatic add_src(input int ch, input logic last, input logic [31:0] d);
        srcq[ch].push_back({last, d});
    endtask

    task automatic expect_beat(input int ch, input logic last, input logic [31:0] d);
        beat_t e;
        e.src  = 2'(ch);
        e.last = last;
        e.data = d;
        sb.push_back(e);
    endtask

    function automatic bit src_busy();
        for (int i = 0; i < WIDTH; i++) if (srcq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < WIDTH; i++) begin
            logic [32:0] h;
            if (srcq[i].size() > 0) begin
                h = srcq[i][0];
                bus.in_vld[i]            = 1'b1;
                bus.in_last[i]           = h[32];
                bus.in_data[i*DW +: DW]  = h[31:0];
            end else begin
                bus.in_vld[i]            = 1'b0;
                bus.in_last[i]           = 1'b0;
                bus.in_data[i*DW +: DW]  = '0;
            end
        end
    endtask

    // Negedge: record the handshakes that the next rising edge will perform
    task automatic sample();
        beat_t e;
        @(negedge clk);
        acc = bus.in_vld & bus.in_rdy;
        if (bus.out_vld && bus.out_rdy) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL beat: got unexpected src %0d data %0h, expected no beat", bus.out_src, bus.out_data);
            end else begin
                e = sb.pop_front();
                chk("beat", {bus.out_src, bus.out_last, bus.out_data}, e);
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (!direct) begin
            for (int i = 0; i < WIDTH; i++) if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            drive_inputs();
        end
    endtask

    task automatic run_drain(input int budget, output int n);
        n = 0;
        while ((sb.size() > 0 || src_busy()) && n < budget) begin
            sample();
            advance();
            n++;
        end
        if (sb.size() > 0 || src_busy()) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d beats outstanding, expected 0", sb.size());
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_out_vld"},  bus.out_vld,  0);
        chk({tag, "_out_last"}, bus.out_last, 0);
        chk({tag, "_out_src"},  bus.out_src,  0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_in_rdy"},   bus.in_rdy,   0);
        chk({tag, "_arb_req"},  bus.arb_req,  0);
    endtask

    task automatic clear_all();
        for (int i = 0; i < WIDTH; i++) srcq[i].delete();
        sb.delete();
        bus.in_vld  = '0;
        bus.in_data = '0;
        bus.in_last = '0;
    endtask

    task automatic do_reset();
        direct    = 1'b0;
        force_en  = 1'b0;
        force_gnt = '0;
        clear_all();
        bus.out_rdy = 1'b1;
        rst = 1'b1;
        #1;
        chk_reset_outs("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_inputs();
    endtask

    initial begin
        //          vld      gnt      rdy      req      src
        vt[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0};
        vt[1] = '{4'b0101, 4'b0001, 4'b0001, 4'b0101, 2'd0};
        vt[2] = '{4'b0101, 4'b0100, 4'b0100, 4'b0101, 2'd2};
        vt[3] = '{4'b0001, 4'b1000, 4'b0000, 4'b0001, 2'd0};
        vt[4] = '{4'b0110, 4'b0110, 4'b0010, 4'b0110, 2'd1};
        vt[5] = '{4'b0011, 4'b1010, 4'b0010, 4'b0011, 2'd1};
        vt[6] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111, 2'd0};
        vt[7] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 2'd3};
        vt[8] = '{4'b1100, 4'b1100, 4'b0100, 4'b1100, 2'd2};

        // Grant qualification table: forced grants, single-beat packets
        do_reset();
        direct   = 1'b1;
        force_en = 1'b1;
        foreach (vt[v]) begin
            bus.in_vld  = vt[v].vld;
            bus.in_last = '1;
            for (int c = 0; c < WIDTH; c++) bus.in_data[c*DW +: DW] = 32'hB000_0000 + 32'(v * 16 + c);
            force_gnt = vt[v].gnt;
            sample();
            chk("tbl_in_rdy",  bus.in_rdy,  vt[v].rdy);
            chk("tbl_arb_req", bus.arb_req, vt[v].req);
            if (vt[v].rdy != '0) expect_beat(int'(vt[v].src), 1'b1, 32'hB000_0000 + 32'(v * 16 + int'(vt[v].src)));
            advance();
        end
        bus.in_vld = '0;
        force_en   = 1'b0;
        direct     = 1'b0;
        run_drain(10, cyc);

        // Single-beat packets on ch0/ch2 alternate at one beat per cycle
        do_reset();
        for (int n = 0; n < 2; n++) begin
            add_src(0, 1'b1, dv(0, n));
            add_src(2, 1'b1, dv(2, n));
            expect_beat(0, 1'b1, dv(0, n));
            expect_beat(2, 1'b1, dv(2, n));
        end
        drive_inputs();
        run_drain(20, cyc);
        chk("t1_cycles", cyc, 5);
        sample();
        chk("t1_drained", bus.out_vld, 0);
        advance();

        // 3-beat packet on ch1 with ch3 waiting
        do_reset();
        add_src(1, 1'b0, dv(1, 0));
        add_src(1, 1'b0, dv(1, 1));
        add_src(1, 1'b1, dv(1, 2));
        add_src(3, 1'b1, dv(3, 0));
`ifdef ARB_MUX_LOCK_EN
        expect_beat(1, 1'b0, dv(1, 0));
        expect_beat(1, 1'b0, dv(1, 1));
        expect_beat(1, 1'b1, dv(1, 2));
        expect_beat(3, 1'b1, dv(3, 0));
`else
        expect_beat(1, 1'b0, dv(1, 0));
        expect_beat(3, 1'b1, dv(3, 0));
        expect_beat(1, 1'b0, dv(1, 1));
        expect_beat(1, 1'b1, dv(1, 2));
`endif
        drive_inputs();
        sample();
        chk("t2_req0", bus.arb_req, 4'b1010);
        advance();
        sample();
`ifdef ARB_MUX_LOCK_EN
        chk("t2_req1", bus.arb_req, 4'b0000);
        chk("t2_rdy1", bus.in_rdy,  4'b0010);
`else
        chk("t2_req1", bus.arb_req, 4'b1010);
`endif
        advance();
        sample();
`ifdef ARB_MUX_LOCK_EN
        chk("t2_req2", bus.arb_req, 4'b0000);
        chk("t2_rdy2", bus.in_rdy,  4'b0010);
`else
        chk("t2_req2", bus.arb_req, 4'b0010);
`endif
        advance();
        run_drain(20, cyc);
        chk("t2_cycles", cyc + 3, 5);

        // Output stall absorbs exactly two beats, no ready feed-through
        do_reset();
        for (int n = 0; n < 6; n++) begin
            add_src(0, 1'b1, dv(0, n));
            expect_beat(0, 1'b1, dv(0, n));
        end
        bus.out_rdy = 1'b0;
        drive_inputs();
        sample(); advance();
        sample(); advance();
        for (int s = 0; s < 2; s++) begin
            sample();
            chk("t3_stall_rdy", bus.in_rdy,  0);
            chk("t3_stall_req", bus.arb_req, 0);
            chk("t3_stall_vld", bus.out_vld, 1);
            advance();
        end
        bus.out_rdy = 1'b1;
        sample();
        chk("t3_no_comb", bus.in_rdy, 4'b0000);
        advance();
        sample();
        chk("t3_resume", bus.in_rdy, 4'b0001);
        advance();
        run_drain(30, cyc);

        // Two-beat packets on ch0 and ch2, packet switch without a bubble
        do_reset();
        for (int c = 0; c < 4; c += 2) begin
            add_src(c, 1'b0, dv(c, 0));
            add_src(c, 1'b1, dv(c, 1));
        end
`ifdef ARB_MUX_LOCK_EN
        expect_beat(0, 1'b0, dv(0, 0));
        expect_beat(0, 1'b1, dv(0, 1));
        expect_beat(2, 1'b0, dv(2, 0));
        expect_beat(2, 1'b1, dv(2, 1));
`else
        expect_beat(0, 1'b0, dv(0, 0));
        expect_beat(2, 1'b0, dv(2, 0));
        expect_beat(0, 1'b1, dv(0, 1));
        expect_beat(2, 1'b1, dv(2, 1));
`endif
        drive_inputs();
        run_drain(20, cyc);
        chk("t6_cycles", cyc, 5);

        // Reset mid-packet with a full buffer, then a fresh packet from ch1
        do_reset();
        bus.out_rdy = 1'b0;
        for (int n = 0; n < 4; n++) add_src(2, (n == 3), dv(2, n));
        drive_inputs();
        sample(); advance();
        sample(); advance();
        sample();
        chk("t5_full", bus.in_rdy, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outs("t5_async");
        clear_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_rdy = 1'b1;
        add_src(1, 1'b1, dv(1, 0));
        expect_beat(1, 1'b1, dv(1, 0));
        drive_inputs();
        run_drain(10, cyc);
        chk("t5_cycles", cyc, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
